// File: rtl/fact_accel.sv
// rtl/fact_accel.sv - memory-mapped factorial accelerator (N, GO/BUSY, STATUS, RESULT)
module fact_accel (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [1:0]  a,
   input  logic [31:0] wd,
   output logic [31:0] rd
);

   typedef enum logic {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [3:0]  n_reg;
   logic [3:0]  cnt;
   logic [31:0] prod;
   logic [31:0] result;
   logic        done;
   logic        err;
   logic        busy;
   logic        go;
   logic        n_ok;

   // Only wd[3:0] feeds registers; upper bits are don't-care on this bus.
   logic        unused_wd;
   assign unused_wd = ^wd[31:4];

   assign busy = (state == CALC);
   assign go   = we && (a == 2'd1) && wd[0];
   assign n_ok = (n_reg <= 4'd12);

   // State register: reset forces IDLE, aborting any calculation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: go with a valid N starts CALC; CALC ends when cnt reaches 1 or 0.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (go && n_ok) begin
               state_next = CALC;
            end
         end
         CALC: begin
            if (cnt <= 4'd1) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: N register, iterative multiply, result/status capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         n_reg  <= 4'd0;
         cnt    <= 4'd0;
         prod   <= 32'd0;
         result <= 32'd0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         if (we && (a == 2'd0)) begin
            n_reg <= wd[3:0];
         end
         case (state)
            IDLE: begin
               if (go) begin
                  if (n_ok) begin
                     cnt  <= n_reg;
                     prod <= 32'd1;
                     done <= 1'b0;
                     err  <= 1'b0;
                  end else begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end
               end
            end
            CALC: begin
               // go requests are ignored here; cnt was captured at start.
               if (cnt > 4'd1) begin
                  prod <= prod * {28'd0, cnt};
                  cnt  <= cnt - 4'd1;
               end else begin
                  result <= prod;
                  done   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Zero-wait-state read mux.
   always_comb begin
      rd = 32'd0;
      case (a)
         2'd0: rd = {28'd0, n_reg};
         2'd1: rd = {31'd0, busy};
         2'd2: rd = {30'd0, err, done};
         2'd3: rd = result;
         default: rd = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_fact_accel.sv
// tb/tb_fact_accel.sv - directed self-checking bench for fact_accel
module tb_fact_accel;

   logic        clk;
   logic        reset;
   logic        we;
   logic [1:0]  a;
   logic [31:0] wd;
   logic [31:0] rd;

   int n_checks = 0;
   int n_pass   = 0;

   fact_accel dut (
      .clk   (clk),
      .reset (reset),
      .we    (we),
      .a     (a),
      .wd    (wd),
      .rd    (rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One bus write, taking effect at the next rising edge; returns #1 after it.
   task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
      @(negedge clk);
      we = 1'b1;
      a  = addr;
      wd = data;
      @(posedge clk);
      #1;
      we = 1'b0;
      wd = 32'd0;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
      a = addr;
      #1;
      data = rd;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until done, starting from 'start'; checks busy stays high meanwhile.
   task automatic wait_done(input string tag, input int start, output int cycles);
      logic [31:0] v;
      cycles = start;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         cycles++;
         bus_read(2'd2, v);
         if (v[0]) return;
         bus_read(2'd1, v);
         if (v != 32'd1) begin
            check({tag, "_busy_during"}, v, 32'd1);
         end
      end
      check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic run_fact(input string tag, input logic [3:0] n,
                           input int exp_cycles, input logic [31:0] exp_res);
      logic [31:0] v;
      int cyc;
      bus_write(2'd0, {28'd0, n});
      bus_write(2'd1, 32'd1);
      bus_read(2'd1, v);
      check({tag, "_busy_start"}, v, 32'd1);
      wait_done(tag, 0, cyc);
      check({tag, "_latency"}, cyc, exp_cycles);
      bus_read(2'd2, v);
      check({tag, "_status"}, v, 32'd1);
      bus_read(2'd3, v);
      check({tag, "_result"}, v, exp_res);
      bus_read(2'd1, v);
      check({tag, "_busy_end"}, v, 32'd0);
   endtask

   initial begin
      logic [31:0] v;
      int cyc;
      reset = 1'b1;
      we    = 1'b0;
      a     = 2'd0;
      wd    = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      // Post-reset reads all zero.
      for (int i = 0; i < 4; i++) begin
         bus_read(i[1:0], v);
         check($sformatf("reset_rd_a%0d", i), v, 32'd0);
      end

      run_fact("n5", 4'd5, 5, 32'd120);
      run_fact("n0", 4'd0, 1, 32'd1);
      run_fact("n1", 4'd1, 1, 32'd1);
      run_fact("n12", 4'd12, 12, 32'h1C8CFC00);

      // Writes to STATUS/RESULT ignored; GO with wd[0]=0 does nothing.
      bus_write(2'd3, 32'hDEADBEEF);
      bus_write(2'd2, 32'h0);
      bus_write(2'd1, 32'hFFFF_FFFE);
      bus_read(2'd3, v);
      check("ro_result", v, 32'h1C8CFC00);
      bus_read(2'd2, v);
      check("ro_status", v, 32'd1);
      bus_read(2'd1, v);
      check("go_bit0_clear", v, 32'd0);

      // N=13 rejected: err+done next cycle, result kept.
      bus_write(2'd0, 32'd13);
      bus_write(2'd1, 32'd1);
      bus_read(2'd2, v);
      check("n13_status", v, 32'd3);
      bus_read(2'd1, v);
      check("n13_busy", v, 32'd0);
      bus_read(2'd3, v);
      check("n13_result", v, 32'h1C8CFC00);

      // Go and N write while busy.
      bus_write(2'd0, 32'd6);
      bus_write(2'd1, 32'd1);
      idle_cycle();
      bus_write(2'd0, 32'd3);
      bus_write(2'd1, 32'd1);
      bus_read(2'd1, v);
      check("busy_go_busy", v, 32'd1);
      wait_done("n6", 3, cyc);
      check("n6_latency", cyc, 6);
      bus_read(2'd3, v);
      check("n6_result", v, 32'd720);
      bus_read(2'd0, v);
      check("n6_nreg", v, 32'd3);
      bus_read(2'd2, v);
      check("n6_status", v, 32'd1);

      // Reset mid-calculation aborts everything.
      bus_write(2'd0, 32'd10);
      bus_write(2'd1, 32'd1);
      repeat (3) idle_cycle();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus_read(i[1:0], v);
         check($sformatf("abort_rd_a%0d", i), v, 32'd0);
      end
      repeat (12) idle_cycle();
      bus_read(2'd3, v);
      check("abort_no_result", v, 32'd0);
      run_fact("n4", 4'd4, 4, 32'd24);

      // Reset wins over a simultaneous write.
      @(negedge clk);
      reset = 1'b1;
      we    = 1'b1;
      a     = 2'd0;
      wd    = 32'd7;
      @(posedge clk);
      #1;
      reset = 1'b0;
      we    = 1'b0;
      bus_read(2'd0, v);
      check("reset_vs_write", v, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
